config_serializer: RTL

Upstream programming stage for the analog backend controller. Accepts a parallel gain setting (gainA1, gainA2) and a start request, pulses the backend's active-low reset, shifts the five gain bits out on the sclk/sdin serial pair in the order the backend consumes them, then waits for the backend's ready flag with a timeout. Runs entirely on the system clock `i_clk`, the same clock the backend uses for its ready sequencing.

---
 rtl/config_serializer.sv | 116 +++++++++++
 1 files changed

// File: rtl/config_serializer.sv
// config_serializer: pulses the backend reset, shifts a 5-bit gain word out on sclk/sdin,
// then waits for the backend ready flag with a timeout.
module config_serializer #(
  parameter int CLK_DIV    = 2,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [1:0] i_gainA1,
  input  logic [2:0] i_gainA2,
  input  logic       i_ready,
  output logic       o_resetbAll,
  output logic       o_sclk,
  output logic       o_sdin,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error
);
  localparam int M1   = CLK_DIV > RST_CYCLES ? CLK_DIV : RST_CYCLES;
  localparam int MAXV = M1 > TIMEOUT ? M1 : TIMEOUT;
  localparam int CW   = $clog2(MAXV) + 1;
  typedef enum logic [1:0] {IDLE, RSTB, SHIFT, WAIT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [4:0] word_q, word_d;
  logic resetb_q, resetb_d, sclk_q, sclk_d, sdin_q, sdin_d;
  logic busy_q, busy_d, done_q, done_d, error_q, error_d;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      word_q   <= '0;
      resetb_q <= 1'b0;
      sclk_q   <= 1'b0;
      sdin_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      word_q   <= word_d;
      resetb_q <= resetb_d;
      sclk_q   <= sclk_d;
      sdin_q   <= sdin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    word_d   = word_q;
    resetb_d = resetb_q;
    sclk_d   = sclk_q;
    sdin_d   = sdin_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = error_q;
    case (state_q)
      IDLE: if (i_start) begin
        state_d  = RSTB;
        word_d   = {i_gainA2, i_gainA1};
        busy_d   = 1'b1;
        error_d  = 1'b0;
        resetb_d = 1'b0;
        cnt_d    = CW'(1);
      end
      RSTB: if (cnt_q == CW'(RST_CYCLES)) begin
        state_d  = SHIFT;
        resetb_d = 1'b1;
        sclk_d   = 1'b0;
        sdin_d   = word_q[0];
        bit_d    = 3'd0;
        cnt_d    = CW'(1);
      end else cnt_d = cnt_q + CW'(1);
      // word_q shifts right per bit so the next bit to send is always word_q[1]
      SHIFT: if (cnt_q == CW'(CLK_DIV)) begin
        cnt_d = CW'(1);
        if (!sclk_q) sclk_d = 1'b1;
        else if (bit_q == 3'd4) begin
          sclk_d  = 1'b0;
          sdin_d  = 1'b0;
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          sclk_d = 1'b0;
          sdin_d = word_q[1];
          word_d = word_q >> 1;
          bit_d  = bit_q + 3'd1;
        end
      end else cnt_d = cnt_q + CW'(1);
      WAIT: if (i_ready || cnt_q == CW'(TIMEOUT - 1)) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        error_d = !i_ready;
        cnt_d   = '0;
        state_d = IDLE;
      end else cnt_d = cnt_q + CW'(1);
      default: state_d = IDLE;
    endcase
  end
  assign o_resetbAll = resetb_q;
  assign o_sclk      = sclk_q;
  assign o_sdin      = sdin_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_error     = error_q;
endmodule
